trainerror_entry_ctrl: RTL

Decides when the link state machine must enter TRAINERROR and sequences that entry. It monitors three error sources: the per-state timeout, local error pulses, and a partner-initiated TRAINERROR entry request on the decoded sideband. It drives `o_trainerror_en` into the TRAINERROR handshake wrapper and waits for `i_TRAINERROR_HS_end`. It then enforces a minimum TRAINERROR residency and issues a single reset request to the LTSM top.

---
 rtl/trainerror_pkg.sv | 22 ++
 rtl/ltsm_timeout_counter.sv | 29 ++
 rtl/trainerror_entry_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/trainerror_pkg.sv
// rtl/trainerror_pkg.sv - shared TRAINERROR states, sideband message codes and cause encodings
package trainerror_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR   = 2'd0,
    ST_HANDSHAKE = 2'd1,
    ST_RESIDE    = 2'd2,
    ST_RESET_REQ = 2'd3
  } te_state_e;

  // Decoded sideband codes, shared with the TRAINERROR handshake wrapper
  localparam int TRAINERROR_entry_req_msg  = 14;
  localparam int TRAINERROR_entry_resp_msg = 15;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_LOCAL   = 2'd2,
    CAUSE_PARTNER = 2'd3
  } te_cause_e;

endpackage

// File: rtl/ltsm_timeout_counter.sv
// rtl/ltsm_timeout_counter.sv - saturating cycle counter with clear, enable and terminal flag
module ltsm_timeout_counter #(
  parameter int CNT_WIDTH = 20,
  parameter int LIMIT     = 799999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 terminal
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LIMIT_V = CNT_WIDTH'(LIMIT);

  // Clear has priority; counting stops at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

  assign terminal = (count == LIMIT_V);

endmodule

// File: rtl/trainerror_entry_ctrl.sv
// rtl/trainerror_entry_ctrl.sv - detects TRAINERROR entry conditions and sequences handshake, residency and reset request
module trainerror_entry_ctrl
  import trainerror_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CNT_WIDTH      = 20,
  parameter int MIN_RESIDENCY  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_state_active,
  input  logic                    i_state_change,
  input  logic                    i_local_error,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_TRAINERROR_HS_end,
  output logic                    o_trainerror_en,
  output logic                    o_in_trainerror,
  output logic                    o_reset_req,
  output logic [1:0]              o_error_cause
);

  localparam logic [CNT_WIDTH-1:0]    TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]    RES_LAST = CNT_WIDTH'(MIN_RESIDENCY - 1);
  localparam logic [SB_MSG_WIDTH-1:0] REQ_MSG  = SB_MSG_WIDTH'(TRAINERROR_entry_req_msg);

  te_state_e             state, state_next;
  te_cause_e             cause, cause_next;
  logic [CNT_WIDTH-1:0]  st_cnt, hs_cnt;
  logic                  st_term, hs_term;
  logic                  partner_err, timeout_err, hs_exit;

  // Timer only runs in MONITOR; it freezes at the limit so it can never run on
  ltsm_timeout_counter #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(TIMEOUT_CYCLES - 1)) u_state_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    ((state != ST_MONITOR) || i_state_change || !i_state_active),
    .enable   (!st_term),
    .count    (st_cnt),
    .terminal (st_term)
  );

  // Shared between handshake timeout and residency; restarted on the HANDSHAKE->RESIDE hop
  ltsm_timeout_counter #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(TIMEOUT_CYCLES - 1)) u_hs_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    ((state == ST_MONITOR) || (state == ST_RESET_REQ) ||
               ((state == ST_HANDSHAKE) && hs_exit)),
    .enable   ((state == ST_HANDSHAKE) || (state == ST_RESIDE)),
    .count    (hs_cnt),
    .terminal (hs_term)
  );

  // Timeout is judged on the pre-clear timer value, so it beats a coincident state change
  assign timeout_err = i_state_active && (st_cnt == TO_LAST);
  assign partner_err = (i_decoded_SB_msg == REQ_MSG);
  assign hs_exit     = i_TRAINERROR_HS_end || hs_term;

  // State, cause and registered outputs follow the next-state decode
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_MONITOR;
      cause           <= CAUSE_NONE;
      o_trainerror_en <= 1'b0;
      o_in_trainerror <= 1'b0;
      o_reset_req     <= 1'b0;
    end else begin
      state           <= state_next;
      cause           <= cause_next;
      o_trainerror_en <= (state_next == ST_HANDSHAKE);
      o_in_trainerror <= (state_next != ST_MONITOR);
      o_reset_req     <= (state_next == ST_RESET_REQ);
    end
  end

  // Next-state and cause selection; partner > local > timeout
  always_comb begin
    state_next = state;
    cause_next = cause;
    case (state)
      ST_MONITOR: begin
        if (partner_err) begin
          state_next = ST_HANDSHAKE;
          cause_next = CAUSE_PARTNER;
        end else if (i_local_error) begin
          state_next = ST_HANDSHAKE;
          cause_next = CAUSE_LOCAL;
        end else if (timeout_err) begin
          state_next = ST_HANDSHAKE;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_HANDSHAKE: begin
        if (hs_exit) begin
          state_next = ST_RESIDE;
        end
      end
      ST_RESIDE: begin
        if (hs_cnt == RES_LAST) begin
          state_next = ST_RESET_REQ;
        end
      end
      ST_RESET_REQ: begin
        state_next = ST_MONITOR;
        cause_next = CAUSE_NONE;
      end
      default: begin
        state_next = ST_MONITOR;
        cause_next = CAUSE_NONE;
      end
    endcase
  end

  assign o_error_cause = cause;

endmodule
